// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - instruction memory clear/load sequencer with core reset control
module imem_load_ctrl #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int START_ADDR   = 1,
  parameter int CLEAR_CYCLES = 2,
  parameter int RESET_HOLD   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_load,
  input  logic [ADDR_W-1:0] load_count,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              core_reset,
  output logic              imem_clear,
  output logic              imem_rw,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              busy,
  output logic              done
);

  // One timer serves both the CLEAR and SETTLE intervals.
  localparam int TIMER_MAX = (CLEAR_CYCLES > RESET_HOLD) ? CLEAR_CYCLES : RESET_HOLD;
  localparam int TW        = $clog2(TIMER_MAX + 1);

  localparam logic [ADDR_W-1:0] START     = ADDR_W'(START_ADDR);
  localparam logic [TW-1:0]     CLR_LAST  = TW'(CLEAR_CYCLES - 1);
  localparam logic [TW-1:0]     HOLD_LAST = TW'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SETTLE,
    S_RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] load_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [TW-1:0]     timer;

  // Sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      load_cnt   <= '0;
      word_cnt   <= '0;
      timer      <= '0;
      wr_ready   <= 1'b0;
      core_reset <= 1'b1;
      imem_clear <= 1'b0;
      imem_rw    <= 1'b1;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // Core is held (IDLE) or running (RUN); a request takes the write port.
        S_IDLE, S_RUN: begin
          if (start_load) begin
            state      <= S_CLEAR;
            load_cnt   <= load_count;
            word_cnt   <= '0;
            timer      <= '0;
            core_reset <= 1'b1;
            imem_clear <= 1'b1;
            imem_rw    <= 1'b0;
            busy       <= 1'b1;
          end
        end

        S_CLEAR: begin
          if (timer == CLR_LAST) begin
            timer      <= '0;
            imem_clear <= 1'b0;
            if (load_cnt != '0) begin
              state    <= S_LOAD;
              wr_ready <= 1'b1;
            end else begin
              state    <= S_SETTLE;
              imem_rw  <= 1'b1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        // Write port stays in write mode; address/data hold between beats so
        // a stall simply rewrites the same word.
        S_LOAD: begin
          if (wr_valid && wr_ready) begin
            imem_addr  <= START + word_cnt;
            imem_wdata <= wr_data;
            word_cnt   <= word_cnt + ADDR_W'(1);
            wr_ready   <= ((word_cnt + ADDR_W'(1)) != load_cnt);
          end else if (word_cnt == load_cnt) begin
            // The final write has been on the port for one cycle.
            state   <= S_SETTLE;
            imem_rw <= 1'b1;
            timer   <= '0;
          end
        end

        S_SETTLE: begin
          if (timer == HOLD_LAST) begin
            state      <= S_RUN;
            core_reset <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - directed self-checking bench for imem_load_ctrl
module tb_imem_load_ctrl;

  logic        clock;
  logic        reset;
  logic        start_load;
  logic [9:0]  load_count;
  logic        wr_valid;
  logic [31:0] wr_data;

  logic        a_ready, a_core_reset, a_clear, a_rw, a_busy, a_done;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic        b_ready, b_core_reset, b_clear, b_rw, b_busy, b_done;
  logic [9:0]  b_addr;
  logic [31:0] b_wdata;

  int vectors = 0;
  int miscompares = 0;

  imem_load_ctrl dut_a (
    .clock(clock), .reset(reset), .start_load(start_load), .load_count(load_count),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(a_ready), .core_reset(a_core_reset),
    .imem_clear(a_clear), .imem_rw(a_rw), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .busy(a_busy), .done(a_done)
  );

  // Same stimulus, PC origin near the top of memory to exercise address wrap.
  imem_load_ctrl #(.START_ADDR(1022)) dut_b (
    .clock(clock), .reset(reset), .start_load(start_load), .load_count(load_count),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(b_ready), .core_reset(b_core_reset),
    .imem_clear(b_clear), .imem_rw(b_rw), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .busy(b_busy), .done(b_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control bits packed as {core_reset, imem_clear, imem_rw, wr_ready, busy, done}.
  task automatic ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'b0, a_core_reset, a_clear, a_rw, a_ready, a_busy, a_done}, {26'b0, exp});
  endtask

  task automatic wbeat(input string tag, input logic [31:0] d, input logic [9:0] ea,
                       input logic [9:0] eb, input logic [5:0] ectl);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    chk({tag, "_addr"}, {22'b0, a_addr}, {22'b0, ea});
    chk({tag, "_data"}, a_wdata, d);
    chk({tag, "_waddr"}, {22'b0, b_addr}, {22'b0, eb});
    ctl({tag, "_ctl"}, ectl);
  endtask

  localparam logic [5:0] C_IDLE   = 6'b101000;
  localparam logic [5:0] C_CLEAR  = 6'b110010;
  localparam logic [5:0] C_LOADR  = 6'b100110;
  localparam logic [5:0] C_LOADN  = 6'b100010;
  localparam logic [5:0] C_SETTLE = 6'b101010;
  localparam logic [5:0] C_RUN1   = 6'b001001;
  localparam logic [5:0] C_RUN    = 6'b001000;

  initial begin
    reset = 1'b1; start_load = 1'b0; load_count = '0; wr_valid = 1'b0; wr_data = '0;
    #2;
    ctl("rst_ctl", C_IDLE);
    chk("rst_addr", {22'b0, a_addr}, 32'h0);
    chk("rst_data", a_wdata, 32'h0);
    tick(); tick();
    reset = 1'b0;
    tick();
    ctl("idle", C_IDLE);

    // wr_valid while idle must not write
    wr_valid = 1'b1; wr_data = 32'hdeadbeef;
    tick();
    wr_valid = 1'b0;
    ctl("idle_valid", C_IDLE);
    chk("idle_valid_data", a_wdata, 32'h0);

    // basic 3-word load
    start_load = 1'b1; load_count = 10'd3;
    tick();
    start_load = 1'b0;
    ctl("t1_clr1", C_CLEAR);
    tick(); ctl("t1_clr2", C_CLEAR);
    tick(); ctl("t1_load", C_LOADR);
    wbeat("t1_b0", 32'h00028083, 10'd1, 10'd1022, C_LOADR);
    wbeat("t1_b1", 32'h00030103, 10'd2, 10'd1023, C_LOADR);
    wbeat("t1_b2", 32'h00008183, 10'd3, 10'd0,    C_LOADN);
    wr_valid = 1'b1; wr_data = 32'hffffffff;
    tick();
    wr_valid = 1'b0;
    ctl("t1_set1", C_SETTLE);
    chk("t1_set1_addr", {22'b0, a_addr}, 32'd3);
    chk("t1_set1_data", a_wdata, 32'h00008183);
    tick(); ctl("t1_set2", C_SETTLE);
    tick(); ctl("t1_set3", C_SETTLE);
    tick(); ctl("t1_run1", C_RUN1);
    tick(); ctl("t1_run2", C_RUN);

    // reload from RUN: 4 words with a 5-cycle stall, start_load during LOAD
    start_load = 1'b1; load_count = 10'd4;
    tick();
    start_load = 1'b0;
    ctl("t2_clr1", C_CLEAR);
    tick(); ctl("t2_clr2", C_CLEAR);
    tick(); ctl("t2_load", C_LOADR);
    wbeat("t2_b0", 32'h11111111, 10'd1, 10'd1022, C_LOADR);
    wbeat("t2_b1", 32'h22222222, 10'd2, 10'd1023, C_LOADR);
    start_load = 1'b1; load_count = 10'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      start_load = 1'b0;
      ctl("t2_stall", C_LOADR);
      chk("t2_stall_addr", {22'b0, a_addr}, 32'd2);
      chk("t2_stall_data", a_wdata, 32'h22222222);
    end
    wbeat("t2_b2", 32'h33333333, 10'd3, 10'd0, C_LOADR);
    wbeat("t2_b3", 32'h44444444, 10'd4, 10'd1, C_LOADN);
    wr_valid = 1'b1; wr_data = 32'h55555555;
    tick();
    wr_valid = 1'b0;
    ctl("t2_set1", C_SETTLE);
    chk("t2_extra_addr", {22'b0, a_addr}, 32'd4);
    chk("t2_extra_data", a_wdata, 32'h44444444);
    tick(); tick(); tick();
    ctl("t2_run1", C_RUN1);

    // zero-length load with wr_valid held high throughout
    wr_valid = 1'b1; wr_data = 32'h66666666;
    start_load = 1'b1; load_count = 10'd0;
    tick();
    start_load = 1'b0;
    ctl("t3_clr1", C_CLEAR);
    tick(); ctl("t3_clr2", C_CLEAR);
    tick(); ctl("t3_set1", C_SETTLE);
    chk("t3_nowrite", a_wdata, 32'h44444444);
    tick(); ctl("t3_set2", C_SETTLE);
    tick(); ctl("t3_set3", C_SETTLE);
    tick(); ctl("t3_run1", C_RUN1);
    wr_valid = 1'b0;

    // reset in the middle of a 5-word load
    start_load = 1'b1; load_count = 10'd5;
    tick();
    start_load = 1'b0;
    tick(); tick();
    ctl("t4_load", C_LOADR);
    wbeat("t4_b0", 32'ha0000001, 10'd1, 10'd1022, C_LOADR);
    wbeat("t4_b1", 32'ha0000002, 10'd2, 10'd1023, C_LOADR);
    #2;
    reset = 1'b1;
    #1;
    ctl("t4_async", C_IDLE);
    chk("t4_async_addr", {22'b0, a_addr}, 32'h0);
    start_load = 1'b1; load_count = 10'd5;
    tick();
    ctl("t4_rst_wins", C_IDLE);
    reset = 1'b0; start_load = 1'b0;
    tick();
    ctl("t4_idle", C_IDLE);
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    ctl("t4_clr1", C_CLEAR);
    tick(); tick();
    ctl("t4_load2", C_LOADR);
    wbeat("t4_c0", 32'hb0000001, 10'd1, 10'd1022, C_LOADR);
    wbeat("t4_c1", 32'hb0000002, 10'd2, 10'd1023, C_LOADR);
    wbeat("t4_c2", 32'hb0000003, 10'd3, 10'd0,    C_LOADR);
    wbeat("t4_c3", 32'hb0000004, 10'd4, 10'd1,    C_LOADR);
    wbeat("t4_c4", 32'hb0000005, 10'd5, 10'd2,    C_LOADN);
    tick(); ctl("t4_set1", C_SETTLE);
    tick(); tick(); tick();
    ctl("t4_run1", C_RUN1);
    tick(); ctl("t4_run2", C_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Sequences program bring-up for the 8-bit RISC-V pipeline. The block clears instruction memory and streams program words into it through a valid/ready interface, writing them at consecutive PCs. It holds the core in reset while it owns the instruction-memory write port, then releases the core to run. It sits between an external program source (host/UART bridge) and the TOP-level ports reset, reset_IF_memory, rw, PC_write and instruction_in.

Parameters:
ADDR_W, 10, instruction-memory address (PC) width
DATA_W, 32, instruction word width
START_ADDR, 1, PC of the first loaded word (PC 0 is left as a bubble)
CLEAR_CYCLES, 2, cycles reset_IF_memory is held high in CLEAR (min 1)
RESET_HOLD, 3, cycles core_reset stays high after the last write (min 1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
start_load  in  1  one-cycle request to begin a load; honoured in IDLE and RUN only
load_count  in  ADDR_W  number of words to load; sampled when start_load is accepted
wr_valid  in  1  program word valid
wr_data  in  DATA_W  program word
wr_ready  out  1  block accepts a word this cycle
core_reset  out  1  drives TOP reset
imem_clear  out  1  drives TOP reset_IF_memory
imem_rw  out  1  0 = write, 1 = read; drives TOP rw
imem_addr  out  ADDR_W  drives TOP PC_write
imem_wdata  out  DATA_W  drives TOP instruction_in
busy  out  1  high in every state except IDLE and RUN
done  out  1  one-cycle pulse on entry to RUN

Behaviour:
- Async reset: state IDLE; core_reset=1, imem_clear=0, imem_rw=1, imem_addr=0, imem_wdata=0, wr_ready=0, busy=0, done=0, word counter=0.
- All outputs are registered. wr_ready is a registered state decode.
- FSM states are IDLE, CLEAR, LOAD, SETTLE and RUN.
- IDLE: core_reset=1, imem_rw=1. On start_load, latch load_count, then go to CLEAR.
- CLEAR: imem_clear=1 for exactly CLEAR_CYCLES cycles. imem_rw=0 throughout. Then:
  - go to LOAD if the latched count is nonzero;
  - go to SETTLE if it is 0.
- LOAD: wr_ready=1 while the count of words accepted is less than load_count.
  - A beat is accepted when wr_valid and wr_ready are both high.
  - The cycle after beat k (k starting at 0), imem_addr=(START_ADDR+k) mod 2^ADDR_W and imem_wdata equals that beat's data, with imem_rw=0.
  - Between beats, imem_addr and imem_wdata hold their last values (rewriting the same word is harmless).
  - wr_ready drops in the cycle after the last beat is accepted. No extra beat can be accepted.
  - After the final write is presented, go to SETTLE.
- wr_valid stalls of any length are tolerated. wr_valid outside LOAD is ignored, and no write occurs.
- SETTLE: imem_rw=1, core_reset=1 for RESET_HOLD cycles. Then go to RUN and pulse done for 1 cycle.
- RUN: core_reset=0, imem_rw=1, wr_ready=0. start_load in RUN goes to CLEAR with core_reset=1 asserted in the same transition.
- start_load while busy is ignored. Changes to load_count after latching have no effect.
- Address wrap: START_ADDR+k wraps modulo 2^ADDR_W. load_count=2^ADDR_W-1 is legal.
- core_reset is high in every state except RUN. The core never runs while imem is written.
- Reset during CLEAR, LOAD or SETTLE aborts immediately to IDLE. Partially loaded words remain in imem, and the next load's CLEAR erases them.
- Simultaneous reset and start_load: reset wins.

Test Plan:
- Reset → all outputs at their reset values. Then start_load with load_count=3 → imem_clear high for 2 cycles, then 3 writes at imem_addr 1, 2, 3 with data 0x00028083, 0x00030103, 0x00008183. Then 3 cycles of core_reset=1, then done pulses and core_reset=0.
- Load of 4 words with wr_valid deasserted for 5 cycles between beats 2 and 3 → exactly 4 writes at addresses 1–4, no duplicates and no data corruption. wr_ready drops after the 4th beat.
- start_load with load_count=0 → CLEAR, then SETTLE, then RUN. No cycle has imem_rw=0 outside CLEAR.
- START_ADDR=1022 with 4 words → writes at 1022, 1023, 0, 1.
- reset asserted mid-LOAD after 2 of 5 beats → asynchronously in IDLE, core_reset=1, wr_ready=0. A new load of 5 then completes normally.
- In RUN, start_load with load_count=2 → core_reset rises next cycle, CLEAR and LOAD repeat, done pulses again. A start_load during LOAD has no effect.
